// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_ctrl_pkg: shared state encoding and phase helpers for run_stall_ctrl | rev 1.0
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int PHASE_LAST = 4;
  localparam int NUM_PHASES = 5;

  // Only an exact one-hot final phase marks an instruction boundary.
  function automatic logic is_last_phase(input logic [NUM_PHASES-1:0] phase);
    return phase == (NUM_PHASES'(1) << PHASE_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wait_watchdog: counts consecutive memory wait cycles, pulses on timeout | rev 1.0
// ---------------------------------------------------------------------------
module mem_wait_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int WCNT_W  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic waiting,
  output logic timeout
);

  logic [WCNT_W-1:0] wcnt;

  assign timeout = enable & waiting & (wcnt == WCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt <= '0;
    end else if (!enable || !waiting || timeout) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/run_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_stall_ctrl: run/step/stop arbitration and stall generation for the phase counter | rev 1.0
// ---------------------------------------------------------------------------
module run_stall_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int WCNT_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_PHASES-1:0] phase,
  input  logic                  run_req,
  input  logic                  step_req,
  input  logic                  stop_req,
  input  logic                  halt_insn,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  not_update,
  output logic                  running,
  output logic                  halted,
  output logic                  mem_fault
);

  state_t state;
  logic   stop_pending;
  logic   waiting;
  logic   advance;
  logic   boundary;
  logic   timeout;

  assign waiting    = mem_req & ~mem_ack;
  assign not_update = (state == IDLE) | waiting;
  assign advance    = ~not_update;
  assign boundary   = advance & is_last_phase(phase);
  assign running    = (state != IDLE);

  mem_wait_watchdog #(
    .TIMEOUT (TIMEOUT),
    .WCNT_W  (WCNT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .enable  (running),
    .waiting (waiting),
    .timeout (timeout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      halted       <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (run_req) begin
            state     <= RUN;
            halted    <= 1'b0;
            mem_fault <= 1'b0;
          end else if (step_req) begin
            state     <= STEP;
            halted    <= 1'b0;
            mem_fault <= 1'b0;
          end
        end
        RUN: begin
          if (timeout) begin
            state        <= IDLE;
            mem_fault    <= 1'b1;
            stop_pending <= 1'b0;
          end else if (boundary && (halt_insn || stop_pending || stop_req)) begin
            state        <= IDLE;
            halted       <= halt_insn;
            stop_pending <= 1'b0;
          end else if (stop_req) begin
            stop_pending <= 1'b1;
          end
        end
        STEP: begin
          if (timeout) begin
            state     <= IDLE;
            mem_fault <= 1'b1;
          end else if (boundary) begin
            state  <= IDLE;
            halted <= halt_insn;
          end
        end
        default: begin
          state        <= IDLE;
          stop_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_stall_ctrl: directed plus randomized checks against a behavioural model | rev 1.0
// ---------------------------------------------------------------------------
module tb_run_stall_ctrl;

  localparam int TIMEOUT = 15;
  localparam int WCNT_W  = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] phase = 5'b00001;
  logic       run_req = 1'b0, step_req = 1'b0, stop_req = 1'b0;
  logic       halt_insn = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic       not_update, running, halted, mem_fault;

  run_stall_ctrl #(.TIMEOUT(TIMEOUT), .WCNT_W(WCNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .phase      (phase),
    .run_req    (run_req),
    .step_req   (step_req),
    .stop_req   (stop_req),
    .halt_insn  (halt_insn),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .not_update (not_update),
    .running    (running),
    .halted     (halted),
    .mem_fault  (mem_fault)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: mode 0 = stopped, 1 = free running, 2 = single instruction
  int m_mode = 0;
  bit m_stop = 0, m_halted = 0, m_fault = 0;
  int m_waits = 0;
  int ph_idx = 0;
  bit exp_stall;

  bit mem_busy = 0;
  int mem_lat = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_stop = 0; m_halted = 0; m_fault = 0; m_waits = 0;
    mem_busy = 0;
  endtask

  task automatic model_edge();
    bit last;
    last = (phase == 5'b10000);
    if (m_mode == 0) begin
      m_waits = 0;
      m_stop  = 0;
      if (run_req || step_req) begin
        m_mode   = run_req ? 1 : 2;
        m_halted = 0;
        m_fault  = 0;
      end
    end else begin
      m_waits = (mem_req && !mem_ack) ? m_waits + 1 : 0;
      if (m_waits == TIMEOUT) begin
        m_mode = 0; m_fault = 1; m_waits = 0; m_stop = 0;
      end else if (m_mode == 1) begin
        if (stop_req) m_stop = 1;
        if (!exp_stall && last && (halt_insn || m_stop)) begin
          m_mode = 0; m_halted = halt_insn; m_stop = 0;
        end
      end else if (!exp_stall && last) begin
        m_mode = 0; m_halted = halt_insn;
      end
    end
  endtask

  // One clock: inputs were set by the caller; check at negedge, update model at posedge.
  task automatic tick();
    #1;
    @(negedge clock);
    exp_stall = (m_mode == 0) || (mem_req && !mem_ack);
    check_eq("not_update", 8'(not_update), 8'(exp_stall));
    check_eq("running", 8'(running), 8'(m_mode != 0));
    check_eq("halted", 8'(halted), 8'(m_halted));
    check_eq("mem_fault", 8'(mem_fault), 8'(m_fault));
    @(posedge clock);
    model_edge();
    #1;
    run_req = 0; step_req = 0; stop_req = 0;
    if (!exp_stall) ph_idx = (ph_idx + 1) % 5;
    phase = 5'(1 << ph_idx);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_not_update", 8'(not_update), 8'd1);
    check_eq("rst_running", 8'(running), 8'd0);
    check_eq("rst_halted", 8'(halted), 8'd0);
    check_eq("rst_mem_fault", 8'(mem_fault), 8'd0);
    model_reset();
    mem_req = 0; mem_ack = 0;
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic until_idle(input int bound);
    int n = 0;
    while (m_mode != 0 && n < bound) begin
      halt_insn = 0;
      tick();
      n++;
    end
    if (m_mode != 0) check_eq("idle_bound", 8'd0, 8'd1);
  endtask

  task automatic until_phase(input int idx, input int bound);
    int n = 0;
    while (ph_idx != idx && n < bound) begin
      tick();
      n++;
    end
    if (ph_idx != idx) check_eq("phase_bound", 8'(ph_idx), 8'(idx));
  endtask

  initial begin
    #3;
    check_eq("init_not_update", 8'(not_update), 8'd1);
    check_eq("init_running", 8'(running), 8'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;

    // Free run, then stop at the boundary.
    run_req = 1; tick();
    check_eq("run_started", 8'(running), 8'd1);
    for (int i = 0; i < 6; i++) tick();
    stop_req = 1; tick();
    until_idle(10);
    check_eq("stop_idx", 8'(ph_idx), 8'd0);

    // Single step: exactly five advances.
    step_req = 1; tick();
    for (int i = 0; i < 5; i++) tick();
    check_eq("step_done", 8'(running), 8'd0);
    check_eq("step_idx", 8'(ph_idx), 8'd0);

    // HLT retirement, then run clears halted.
    run_req = 1; tick();
    for (int i = 0; i < 12 && m_mode != 0; i++) begin
      halt_insn = (ph_idx == 4);
      tick();
    end
    halt_insn = 0;
    check_eq("hlt_halted", 8'(halted), 8'd1);
    run_req = 1; tick();
    check_eq("hlt_cleared", 8'(halted), 8'd0);

    // Three wait states in phase 2.
    until_phase(2, 10);
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) tick();
    mem_ack = 1; tick();
    mem_req = 0; mem_ack = 0;
    check_eq("wait_no_fault", 8'(mem_fault), 8'd0);
    stop_req = 1; tick();
    until_idle(10);

    // Watchdog timeout freezes the phase; run resumes from it.
    run_req = 1; tick();
    until_phase(2, 10);
    mem_req = 1;
    for (int i = 0; i < TIMEOUT; i++) tick();
    mem_req = 0;
    check_eq("to_fault", 8'(mem_fault), 8'd1);
    check_eq("to_idle", 8'(running), 8'd0);
    check_eq("to_phase", 8'(ph_idx), 8'd2);
    run_req = 1; tick();
    check_eq("to_resume", 8'(mem_fault), 8'd0);
    tick();

    // Stop pending then async reset in phase 3.
    until_phase(1, 10);
    stop_req = 1; tick();
    until_phase(3, 10);
    pulse_reset();
    tick();
    run_req = 1; tick();
    stop_req = 1; tick();
    until_idle(10);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        pulse_reset();
      end
      run_req  = ($urandom_range(0, 19) == 0);
      step_req = ($urandom_range(0, 19) == 0);
      stop_req = ($urandom_range(0, 14) == 0);
      halt_insn = (ph_idx == 4) && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 24) == 0) phase = 5'($urandom);
      if (!mem_busy && m_mode != 0 && $urandom_range(0, 3) == 0) begin
        mem_busy = 1;
        mem_lat  = $urandom_range(0, 18);
      end
      mem_req = mem_busy;
      mem_ack = mem_busy && (mem_lat == 0);
      tick();
      if (mem_busy) begin
        if (mem_lat == 0) mem_busy = 0;
        else if (m_mode != 0) mem_lat--;
      end
      if (m_mode == 0) mem_busy = 0;
      mem_req = 0; mem_ack = 0; halt_insn = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_stall_ctrl.md
Name: run_stall_ctrl

Overview:
- Execution-control stage directly upstream of the 5-phase counter. Generates the counter's not-update (stall) input.
- Arbitrates front-panel run/step/stop requests, HLT retirement and memory wait states.
- Watchdog: a memory access that is never acknowledged forces the block to IDLE and raises a fault.
- Consumes the counter's one-hot phase to locate instruction boundaries (phase[4] = final phase).

Parameters:
- TIMEOUT, 15, consecutive unacknowledged memory-wait cycles before fault (1..2^WCNT_W-1)
- WCNT_W, 4, width of the wait-cycle counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- phase  in  5  one-hot phase from phase counter; bit4 = last phase of instruction
- run_req  in  1  single-cycle pulse: start free-running execution
- step_req  in  1  single-cycle pulse: execute to end of current instruction
- stop_req  in  1  single-cycle pulse: stop at next instruction boundary
- halt_insn  in  1  decoded HLT, valid during phase[4]
- mem_req  in  1  datapath memory access in progress this cycle
- mem_ack  in  1  memory completes access this cycle
- not_update  out  1  stall to phase counter; 1 = hold phase
- running  out  1  state != IDLE
- halted  out  1  sticky: last stop caused by HLT
- mem_fault  out  1  sticky: last stop caused by memory timeout

Behaviour:
- States: IDLE, RUN, STEP. Registered state; encoding in package.
- Reset (reset=0, async): state=IDLE, stop_pending=0, wcnt=0, halted=0, mem_fault=0. Hence not_update=1, running=0.
- not_update is combinational, zero-cycle: (state==IDLE) | (mem_req & ~mem_ack).
- advance = ~not_update, i.e. the phase counter steps on this edge.
- mem_ack with mem_req in the same cycle: no stall, so zero wait states are possible.
- IDLE:
  - run_req -> RUN; else step_req -> STEP. run_req wins if both are asserted.
  - Leaving IDLE clears halted and mem_fault.
  - stop_req is ignored.
- RUN:
  - stop_req sets stop_pending.
  - On advance & phase[4]: if halt_insn -> IDLE, halted=1; else if (stop_pending | stop_req) -> IDLE.
  - run_req and step_req are ignored.
- STEP:
  - On advance & phase[4] -> IDLE; halted=halt_insn.
  - run_req, step_req and stop_req are ignored.
- Phase counter behaviour: it has already stepped past phase[4] on the exit edge. Next instruction starts at phase[0] on the next run/step.
- Entering IDLE by any path clears stop_pending.
- Watchdog (RUN/STEP only):
  - wcnt increments each cycle mem_req & ~mem_ack; clears otherwise.
  - When wcnt==TIMEOUT-1 and still waiting: next state IDLE, mem_fault=1, wcnt=0.
  - Phase is frozen mid-instruction. A later run/step resumes from that phase.
- wcnt held at 0 in IDLE.
- Non-one-hot or zero phase: treated as not phase[4]; no boundary detected, no error.
- Reset asserted mid-wait or mid-instruction: immediate IDLE. Sticky flags cleared.
- No latency on not_update. State transitions take effect on the next rising edge.

Decomposition:
- Shared package run_ctrl_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, STEP=2'd2
  - PHASE_LAST bit index = 4
  - NUM_PHASES = 5
- One natural sub-module, mem_wait_watchdog: wcnt counter plus compare. Inputs clock, reset, enable, waiting. Output timeout pulse.

Test Plan:
- Reset then run_req pulse, no mem_req -> running=1 next cycle. not_update=0. Phases advance 1,2,4,8,16,1.
- step_req at phase=5'b00001 -> exactly 5 advances. After the edge with phase=5'b10000, state=IDLE, not_update=1, phase back at 5'b00001.
- RUN with halt_insn=1 during phase 5'b10000 -> IDLE, halted=1. A subsequent run_req clears halted.
- mem_req=1 in phase 5'b00100, mem_ack after 3 cycles -> not_update=1 for exactly 3 cycles. Phase stays 5'b00100. No fault.
- mem_req=1, mem_ack never, TIMEOUT=15 -> after 15 stalled cycles, IDLE and mem_fault=1, phase still 5'b00100. Then run_req resumes at 5'b00100.
- stop_req mid-instruction in phase 5'b00010, then reset=0 asserted for 1 cycle in phase 5'b01000 -> immediate IDLE, all flags 0, stop_pending cleared. Separately, stop_req without reset -> IDLE only after phase 5'b10000 advance.
